// File: rtl/fmac_feeder.sv
// ----------------------------------------------------------------------------
// fmac_feeder
//
// Purpose:
//   Buffers {x,y} operand pairs in a small FIFO and replays them into an
//   external multiply-accumulate unit, one dot product per start request.
//   Each run clears the MAC, issues one pair every two cycles and then waits
//   out the MAC register latency before pulsing done.
//
// Ports:
//   CLK        in   clock, all state changes on the rising edge
//   RESET      in   synchronous, active-low reset
//   in_valid   in   operand pair offered
//   in_ready   out  FIFO can accept a pair
//   in_x/in_y  in   8-bit operand pair
//   start      in   one-cycle run request (accepted only when idle)
//   vlen       in   number of pairs in the run, sampled with start
//   x_out/y_out out registered operands driven into the MAC
//   mac_rst_n  out  registered drive for the MAC reset input
//   busy       out  high from the cycle after an accepted start until done
//   done       out  one-cycle pulse, MAC result valid
//   ovf        out  run sum exceeded 65025 (optional checker)
//
// Configuration:
//   FMAC_FEEDER_OVF_CHECK_EN  define to build the 18-bit shadow sum and the
//                             sticky ovf flag; otherwise ovf is tied low.
// ----------------------------------------------------------------------------
module fmac_feeder #(
    parameter int DEPTH  = 8,
    parameter int VLEN_W = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_x,
    input  logic [7:0]        in_y,
    input  logic              start,
    input  logic [VLEN_W-1:0] vlen,
    output logic [7:0]        x_out,
    output logic [7:0]        y_out,
    output logic              mac_rst_n,
    output logic              busy,
    output logic              done,
    output logic              ovf
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ISSUE,
        BUBBLE,
        WAIT1,
        WAIT2,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [15:0]       mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              ready_q;
    logic [VLEN_W-1:0] remaining_q, remaining_d;
    logic [7:0]        x_q, y_q, x_d, y_d;
    logic              mac_rst_n_q, mac_rst_n_d;

    logic              full, empty, push, pop;
    logic [15:0]       head;

    // ready_q keeps in_ready low while reset is held and for the reset edge
    // itself, so the first push can only happen after release.
    assign full     = (count_q == FULL_COUNT);
    assign empty    = (count_q == '0);
    assign in_ready = ready_q && !full;
    assign push     = in_valid && in_ready;
    assign pop      = (state_q == ISSUE) && !empty;
    assign head     = mem_q[rd_ptr_q];

    // FIFO bookkeeping; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array, no reset needed: the pointers define what is valid.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_x, in_y};
        end
    end

    // Next-state and registered-output logic. Operands default to zero so
    // every state other than a successful ISSUE presents 0 to the MAC.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        x_d         = 8'h00;
        y_d         = 8'h00;
        case (state_q)
            IDLE: begin
                if (start) begin
                    remaining_d = vlen;
                    state_d     = CLEAR;
                end
            end
            CLEAR: begin
                state_d = (remaining_q != '0) ? ISSUE : WAIT1;
            end
            ISSUE: begin
                // An empty FIFO simply stalls here with zero operands.
                if (!empty) begin
                    x_d = head[15:8];
                    y_d = head[7:0];
                    if (remaining_q != '0) begin
                        remaining_d = remaining_q - VLEN_W'(1);
                    end
                    state_d = BUBBLE;
                end
            end
            BUBBLE: begin
                state_d = (remaining_q != '0) ? ISSUE : WAIT1;
            end
            WAIT1:   state_d = WAIT2;
            WAIT2:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Registered from the next state so the MAC sees reset exactly
        // during the CLEAR cycle.
        mac_rst_n_d = (state_d != CLEAR);
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            x_q         <= 8'h00;
            y_q         <= 8'h00;
            mac_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            x_q         <= x_d;
            y_q         <= y_d;
            mac_rst_n_q <= mac_rst_n_d;
        end
    end

    assign x_out     = x_q;
    assign y_out     = y_q;
    assign mac_rst_n = mac_rst_n_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

`ifdef FMAC_FEEDER_OVF_CHECK_EN
    localparam logic [17:0] SUM_LIMIT = 18'd65025;

    logic [17:0] sum_q, sum_d;
    logic        ovf_q, ovf_d;
    logic [15:0] prod;

    assign prod = {8'h00, head[15:8]} * {8'h00, head[7:0]};

    // Shadow sum clears on entry to CLEAR so ovf reads 0 for the new run.
    // The sum may wrap on very long runs, but ovf is sticky by then.
    always_comb begin
        sum_d = sum_q;
        ovf_d = ovf_q;
        if (state_d == CLEAR) begin
            sum_d = '0;
            ovf_d = 1'b0;
        end else if (pop) begin
            sum_d = sum_q + {2'b00, prod};
            ovf_d = ovf_q || (sum_d > SUM_LIMIT);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            sum_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule
